// File: rtl/interrupt_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | interrupt_unit: machine-level interrupt sources, synchronizer, mtime timer |
// | Optional internal timer: define INTR_UNIT_MTIMER_EN.  Revision: 1.0        |
// +----------------------------------------------------------------------------+
module interrupt_unit #(
  parameter int SYNC_STAGES    = 2,
  parameter int MTIME_PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        msip,
  input  logic        timer_irq,
  input  logic        mstatus_mie,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        interrupt_take,
  input  logic        tmr_we,
  input  logic [1:0]  tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic [2:0]  mip,
  output logic        interrupt_pending,
  output logic [3:0]  interrupt_cause,
  output logic [3:0]  taken_cause,
  output logic        take_spurious
);

  localparam logic [3:0] c_CAUSE_MEI = 4'd11;
  localparam logic [3:0] c_CAUSE_MSI = 4'd3;
  localparam logic [3:0] c_CAUSE_MTI = 4'd7;

  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic                   w_mtip_next;
  logic [2:0]             w_en;
  logic [3:0]             w_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ext_sync <= '0;
    else     r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_irq};
  end

`ifdef INTR_UNIT_MTIMER_EN
  localparam int              c_PW   = (MTIME_PRESCALE > 1) ? $clog2(MTIME_PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PMAX = c_PW'(MTIME_PRESCALE - 1);

  logic [c_PW-1:0] r_presc;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic            w_tick;
  logic            w_unused_timer_irq;

  assign w_unused_timer_irq = timer_irq;
  assign w_tick             = (r_presc == c_PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      // A software write to mtime wins over the prescaled increment.
      if (tmr_we && tmr_addr == 2'd0)      r_mtime[31:0]  <= tmr_wdata;
      else if (tmr_we && tmr_addr == 2'd1) r_mtime[63:32] <= tmr_wdata;
      else if (w_tick)                     r_mtime        <= r_mtime + 64'd1;
      if (tmr_we && tmr_addr == 2'd2) r_mtimecmp[31:0]  <= tmr_wdata;
      if (tmr_we && tmr_addr == 2'd3) r_mtimecmp[63:32] <= tmr_wdata;
    end
  end

  assign w_mtip_next = (r_mtime >= r_mtimecmp);

  always_comb begin
    tmr_rdata = '0;
    case (tmr_addr)
      2'd0:    tmr_rdata = r_mtime[31:0];
      2'd1:    tmr_rdata = r_mtime[63:32];
      2'd2:    tmr_rdata = r_mtimecmp[31:0];
      default: tmr_rdata = r_mtimecmp[63:32];
    endcase
  end
`else
  logic [SYNC_STAGES-1:0] r_tmr_sync;
  logic                   w_unused_tmr_bus;

  assign w_unused_tmr_bus = ^{tmr_we, tmr_addr, tmr_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tmr_sync <= '0;
    else     r_tmr_sync <= {r_tmr_sync[SYNC_STAGES-2:0], timer_irq};
  end

  assign w_mtip_next = r_tmr_sync[SYNC_STAGES-1];
  assign tmr_rdata   = '0;
`endif

  assign w_en = mip & {mie_meie, mie_mtie, mie_msie};

  always_comb begin
    w_cause = '0;
    if (mstatus_mie) begin
      if (w_en[2])      w_cause = c_CAUSE_MEI;
      else if (w_en[0]) w_cause = c_CAUSE_MSI;
      else if (w_en[1]) w_cause = c_CAUSE_MTI;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip               <= '0;
      interrupt_pending <= 1'b0;
      interrupt_cause   <= '0;
      taken_cause       <= '0;
      take_spurious     <= 1'b0;
    end else begin
      mip               <= {r_ext_sync[SYNC_STAGES-1], w_mtip_next, msip};
      interrupt_pending <= mstatus_mie && (|w_en);
      interrupt_cause   <= w_cause;
      take_spurious     <= interrupt_take && !interrupt_pending;
      // Capture the registered cause so a same-cycle source change cannot leak in.
      if (interrupt_take && interrupt_pending) taken_cause <= interrupt_cause;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_unit.sv
`default_nettype none
// Self-checking bench for interrupt_unit; timer scenarios build only with INTR_UNIT_MTIMER_EN.
module tb_interrupt_unit;

  logic        clk = 1'b0;
  logic        rst, ext_irq, msip, timer_irq, mstatus_mie;
  logic        mie_msie, mie_mtie, mie_meie, interrupt_take, tmr_we;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_wdata, tmr_rdata;
  logic [2:0]  mip;
  logic        interrupt_pending, take_spurious;
  logic [3:0]  interrupt_cause, taken_cause;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

`ifdef INTR_UNIT_MTIMER_EN
  localparam logic [31:0] EXP_CMP_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_CMP_RST = 32'h0;
`endif

  interrupt_unit dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .msip(msip), .timer_irq(timer_irq),
    .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .interrupt_take(interrupt_take), .tmr_we(tmr_we), .tmr_addr(tmr_addr),
    .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata), .mip(mip),
    .interrupt_pending(interrupt_pending), .interrupt_cause(interrupt_cause),
    .taken_cause(taken_cause), .take_spurious(take_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tmr_write(input logic [1:0] a, input logic [31:0] d);
    tmr_we = 1'b1; tmr_addr = a; tmr_wdata = d;
    tick();
    tmr_we = 1'b0;
  endtask

  task automatic clear_inputs();
    ext_irq = 0; msip = 0; timer_irq = 0; mstatus_mie = 0;
    mie_msie = 0; mie_mtie = 0; mie_meie = 0; interrupt_take = 0;
    tmr_we = 0; tmr_addr = 0; tmr_wdata = 0;
  endtask

  task automatic test_reset();
    sb.push_back({14'd0, 3'b000, 4'd0, 4'd0, 1'b0, 1'b0});
    e = sb.pop_front(); n_chk++;
    if ({mip, interrupt_cause, taken_cause, take_spurious, interrupt_pending} !== e[13:0]) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h required %0h",
               {mip, interrupt_cause, taken_cause, take_spurious, interrupt_pending}, e[13:0]);
    end
    for (int a = 2; a <= 3; a++) begin
      tmr_addr = 2'(a); #1;
      sb.push_back(EXP_CMP_RST);
      e = sb.pop_front(); n_chk++;
      if (tmr_rdata !== e) begin
        n_err++; $display("FAIL reset_cmp_addr%0d: got %h required %h", a, tmr_rdata, e);
      end
    end
    msip = 1; mie_msie = 1; mstatus_mie = 1;
    sb.push_back(32'd1);
    repeat (3) tick();
    e = sb.pop_front(); n_chk++;
    if (interrupt_pending !== e[0]) begin
      n_err++; $display("FAIL pre_async_pending: got %b required %b", interrupt_pending, e[0]);
    end
    #3 rst = 1'b1;
    sb.push_back({25'd0, 3'b000, 4'd0});
    #1;
    e = sb.pop_front(); n_chk++;
    if ({mip, interrupt_cause, interrupt_pending} !== e[7:0]) begin
      n_err++;
      $display("FAIL async_reset: got %h required %h", {mip, interrupt_cause, interrupt_pending}, e[7:0]);
    end
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ext_latency();
    mie_meie = 1; mstatus_mie = 1; ext_irq = 1;
    sb.push_back({27'd0, 4'd0, 1'b0});
    sb.push_back({27'd0, 4'd11, 1'b1});
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i >= 3) begin
        e = sb.pop_front(); n_chk++;
        if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
          n_err++; $display("FAIL ext_rise_cycle%0d: got %h required %h", i,
                            {interrupt_cause, interrupt_pending}, e[4:0]);
        end
      end
    end
    ext_irq = 0;
    sb.push_back({27'd0, 4'd11, 1'b1});
    sb.push_back({27'd0, 4'd0, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i >= 3) begin
        e = sb.pop_front(); n_chk++;
        if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
          n_err++; $display("FAIL ext_fall_cycle%0d: got %h required %h", i,
                            {interrupt_cause, interrupt_pending}, e[4:0]);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    mie_meie = 1; mie_msie = 1; mie_mtie = 1; mstatus_mie = 1;
    ext_irq = 1; msip = 1;
`ifdef INTR_UNIT_MTIMER_EN
    tmr_write(2'd2, 32'd0);
    tmr_write(2'd3, 32'd0);
`else
    timer_irq = 1;
`endif
    sb.push_back({24'd0, 3'b111, 4'd11, 1'b1});
    repeat (6) tick();
    e = sb.pop_front(); n_chk++;
    if ({mip, interrupt_cause, interrupt_pending} !== e[7:0]) begin
      n_err++; $display("FAIL prio_all: got %h required %h", {mip, interrupt_cause, interrupt_pending}, e[7:0]);
    end
    interrupt_take = 1;
    sb.push_back({28'd0, 4'd11});
    tick();
    interrupt_take = 0;
    e = sb.pop_front(); n_chk++;
    if (taken_cause !== e[3:0]) begin
      n_err++; $display("FAIL take_mei: got %0d required %0d", taken_cause, e[3:0]);
    end
    ext_irq = 0;
    sb.push_back({27'd0, 4'd3, 1'b1});
    repeat (5) tick();
    e = sb.pop_front(); n_chk++;
    if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
      n_err++; $display("FAIL prio_no_ext: got %h required %h", {interrupt_cause, interrupt_pending}, e[4:0]);
    end
    msip = 0;
    sb.push_back({27'd0, 4'd7, 1'b1});
    repeat (3) tick();
    e = sb.pop_front(); n_chk++;
    if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
      n_err++; $display("FAIL prio_timer_only: got %h required %h", {interrupt_cause, interrupt_pending}, e[4:0]);
    end
    mstatus_mie = 0;
    sb.push_back({27'd0, 4'd0, 1'b0});
    tick();
    e = sb.pop_front(); n_chk++;
    if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
      n_err++; $display("FAIL prio_global_off: got %h required %h", {interrupt_cause, interrupt_pending}, e[4:0]);
    end
`ifdef INTR_UNIT_MTIMER_EN
    tmr_write(2'd3, 32'hFFFF_FFFF);
`else
    timer_irq = 0;
`endif
    repeat (6) tick();
    clear_inputs();
  endtask

  task automatic test_take();
    mie_msie = 1; mie_meie = 1; mstatus_mie = 1; msip = 1;
    sb.push_back({27'd0, 4'd3, 1'b1});
    repeat (3) tick();
    e = sb.pop_front(); n_chk++;
    if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
      n_err++; $display("FAIL take_setup: got %h required %h", {interrupt_cause, interrupt_pending}, e[4:0]);
    end
    interrupt_take = 1; ext_irq = 1;
    sb.push_back({27'd0, 4'd3, 1'b0});
    tick();
    interrupt_take = 0;
    e = sb.pop_front(); n_chk++;
    if ({taken_cause, take_spurious} !== e[4:0]) begin
      n_err++; $display("FAIL take_msi_race: got %h required %h", {taken_cause, take_spurious}, e[4:0]);
    end
    ext_irq = 0; msip = 0;
    sb.push_back(32'd0);
    repeat (6) tick();
    e = sb.pop_front(); n_chk++;
    if (interrupt_pending !== e[0]) begin
      n_err++; $display("FAIL take_idle: got %b required %b", interrupt_pending, e[0]);
    end
    interrupt_take = 1;
    sb.push_back({27'd0, 4'd3, 1'b1});
    sb.push_back({27'd0, 4'd3, 1'b0});
    tick();
    interrupt_take = 0;
    e = sb.pop_front(); n_chk++;
    if ({taken_cause, take_spurious} !== e[4:0]) begin
      n_err++; $display("FAIL take_spurious: got %h required %h", {taken_cause, take_spurious}, e[4:0]);
    end
    tick();
    e = sb.pop_front(); n_chk++;
    if ({taken_cause, take_spurious} !== e[4:0]) begin
      n_err++; $display("FAIL spurious_one_cycle: got %h required %h", {taken_cause, take_spurious}, e[4:0]);
    end
    clear_inputs();
  endtask

`ifdef INTR_UNIT_MTIMER_EN
  task automatic test_timer();
    tmr_write(2'd2, 32'd10);
    tmr_write(2'd3, 32'd0);
    tmr_write(2'd1, 32'd0);
    tmr_write(2'd0, 32'd0);
    tmr_addr = 2'd0;
    sb.push_back({31'd0, 1'b0});
    sb.push_back({31'd0, 1'b0});
    sb.push_back({31'd0, 1'b1});
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) begin
        n_chk++;
        if (tmr_rdata !== 32'(i)) begin
          n_err++; $display("FAIL mtime_count: got %0d required %0d", tmr_rdata, i);
        end
      end
      if (i >= 9) begin
        e = sb.pop_front(); n_chk++;
        if (mip[1] !== e[0]) begin
          n_err++; $display("FAIL mtip_cycle%0d: got %b required %b", i, mip[1], e[0]);
        end
      end
    end
    tmr_write(2'd0, 32'hFFFF_FFFF);
    tmr_write(2'd1, 32'hFFFF_FFFF);
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 2; a++) begin
        tmr_addr = 2'(a); #1;
        e = sb.pop_front(); n_chk++;
        if (tmr_rdata !== e) begin
          n_err++; $display("FAIL mtime_wrap_step%0d_addr%0d: got %h required %h", k, a, tmr_rdata, e);
        end
      end
      if (k == 0) tick();
    end
    tmr_we = 1; tmr_addr = 2'd0; tmr_wdata = 32'h55;
    sb.push_back(32'h0);
    sb.push_back(32'h55);
    #1;
    e = sb.pop_front(); n_chk++;
    if (tmr_rdata !== e) begin
      n_err++; $display("FAIL read_during_write: got %h required %h", tmr_rdata, e);
    end
    tick();
    tmr_we = 0;
    e = sb.pop_front(); n_chk++;
    if (tmr_rdata !== e) begin
      n_err++; $display("FAIL write_priority: got %h required %h", tmr_rdata, e);
    end
    clear_inputs();
  endtask
`else
  task automatic test_macro_off();
    mie_mtie = 1; mstatus_mie = 1; timer_irq = 1;
    sb.push_back({27'd0, 4'd0, 1'b0});
    sb.push_back({27'd0, 4'd7, 1'b1});
    sb.push_back({27'd0, 4'd0, 1'b0});
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) timer_irq = 0;
      if (i >= 3) begin
        e = sb.pop_front(); n_chk++;
        if ({interrupt_cause, interrupt_pending} !== e[4:0]) begin
          n_err++; $display("FAIL timer_irq_cycle%0d: got %h required %h", i,
                            {interrupt_cause, interrupt_pending}, e[4:0]);
        end
      end
    end
    for (int a = 0; a < 4; a++) begin
      tmr_write(2'(a), 32'hA5A5_0000 | 32'(a));
      tmr_addr = 2'(a); #1;
      sb.push_back(32'h0);
      e = sb.pop_front(); n_chk++;
      if (tmr_rdata !== e) begin
        n_err++; $display("FAIL rdata_zero_addr%0d: got %h required %h", a, tmr_rdata, e);
      end
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_ext_latency();
    test_priority();
    test_take();
`ifdef INTR_UNIT_MTIMER_EN
    test_timer();
`else
    test_macro_off();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
